// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame instruction cache between datapath fetch and memory arbiter.
// Latency: hit 0 cycles; miss holds in FILL until iwait drops, then IDLE re-evaluates the request.
// Backpressure: iwait stalls FILL; ihit stays low meanwhile. Optional counters via ICACHE_STATS_EN.
module icache_responder #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FILL} state_t;

    state_t           state;
    state_t           next_state;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [SETS];
    logic [29:0]      miss_addr;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             hit_raw;
    logic             start_fill;
    logic             fill_done;
    logic             unused_addr_bits;

    assign req_idx          = imemaddr[IDX_W+1:2];
    assign req_tag          = imemaddr[31:IDX_W+2];
    assign fill_idx         = miss_addr[IDX_W-1:0];
    assign fill_tag         = miss_addr[29:IDX_W];
    assign unused_addr_bits = ^imemaddr[1:0];

    assign hit_raw    = imemREN & valid[req_idx] & (tags[req_idx] == req_tag);
    assign start_fill = (state == IDLE) & imemREN & ~hit_raw & ~flush;
    assign fill_done  = (state == FILL) & ~iwait;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_fill) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (flush || !iwait) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ihit     = 1'b0;
        imemload = 32'd0;
        iREN     = 1'b0;
        iaddr    = 32'd0;
        case (state)
            IDLE: begin
                if (hit_raw && !flush) begin
                    ihit     = 1'b1;
                    imemload = data[req_idx];
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = {miss_addr, 2'b00};
            end
            default: ;
        endcase
    end

    // A flush landing on the completing fill wins: the frame stays invalid.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            valid <= '0;
        end else if (fill_done) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_done && !flush) begin
            data[fill_idx] <= iload;
            tags[fill_idx] <= fill_tag;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            miss_addr <= 30'd0;
        end else if (start_fill) begin
            miss_addr <= imemaddr[31:2];
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (ihit && hit_count != 32'hFFFF_FFFF) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_fill && miss_count != 32'hFFFF_FFFF) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: per-cycle vector table with an expected-output scoreboard.
module tb_icache_responder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 CLK = ~CLK;

    icache_responder #(.SETS(16)) dut (
        .CLK(CLK),
        .RST(RST),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .ihit(ihit),
        .imemload(imemload),
        .flush(flush),
        .iREN(iREN),
        .iaddr(iaddr),
        .iwait(iwait),
        .iload(iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    typedef struct {
        logic        rst;
        logic        ren;
        logic [31:0] addr;
        logic        fl;
        logic        iw;
        logic [31:0] ld;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_ren;
        logic [31:0] e_addr;
        logic        cs;
        logic [31:0] e_hc;
        logic [31:0] e_mc;
    } vec_t;

    vec_t tbl[$];
    vec_t hand[$];
    vec_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic ren, input logic [31:0] addr,
                                input logic fl, input logic iw, input logic [31:0] ld,
                                input logic eh, input logic [31:0] el, input logic er,
                                input logic [31:0] ea);
        vec_t v;
        v.rst = rst; v.ren = ren; v.addr = addr; v.fl = fl; v.iw = iw; v.ld = ld;
        v.e_hit = eh; v.e_load = el; v.e_ren = er; v.e_addr = ea;
        v.cs = 1'b0; v.e_hc = 32'd0; v.e_mc = 32'd0;
        return v;
    endfunction

    function automatic vec_t with_stats(input vec_t v, input logic [31:0] hc, input logic [31:0] mc);
        vec_t r;
        r = v;
        r.cs = 1'b1; r.e_hc = hc; r.e_mc = mc;
        return r;
    endfunction

    task automatic run_list(input string tag, input vec_t lst[$]);
        vec_t e;
        for (int i = 0; i < lst.size(); i++) begin
            RST      = lst[i].rst;
            imemREN  = lst[i].ren;
            imemaddr = lst[i].addr;
            flush    = lst[i].fl;
            iwait    = lst[i].iw;
            iload    = lst[i].ld;
            sb.push_back(lst[i]);
            @(negedge CLK);
            e = sb.pop_front();
            chk($sformatf("%s%0d ihit", tag, i), {31'd0, ihit}, {31'd0, e.e_hit});
            chk($sformatf("%s%0d imemload", tag, i), imemload, e.e_load);
            chk($sformatf("%s%0d iREN", tag, i), {31'd0, iREN}, {31'd0, e.e_ren});
            chk($sformatf("%s%0d iaddr", tag, i), iaddr, e.e_addr);
`ifdef ICACHE_STATS_EN
            if (e.cs) begin
                chk($sformatf("%s%0d hit_count", tag, i), hit_count, e.e_hc);
                chk($sformatf("%s%0d miss_count", tag, i), miss_count, e.e_mc);
            end
`endif
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        RST = 1'b1; imemREN = 1'b0; imemaddr = 32'd0; flush = 1'b0; iwait = 1'b1; iload = 32'd0;
        repeat (2) @(posedge CLK);
        #1;

        //            rst ren addr          fl iw iload          ihit imemload      iREN iaddr
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 1, 32'h0,         0, 32'h0,         1, 32'h40));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 1, 32'h0,         0, 32'h0,         1, 32'h40));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 0, 32'h8C22_0004, 0, 32'h0,         1, 32'h40));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 1, 32'h0,         1, 32'h8C22_0004, 0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 1, 32'h0,         1, 32'h8C22_0004, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0000_0040, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        // same index 0, different tag: evicts 0x40
        tbl.push_back(mk(0, 1, 32'h0000_0080, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0080, 0, 0, 32'h1111_1111, 0, 32'h0,         1, 32'h80));
        tbl.push_back(mk(0, 1, 32'h0000_0080, 0, 1, 32'h0,         1, 32'h1111_1111, 0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 0, 32'h8C22_0004, 0, 32'h0,         1, 32'h40));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 1, 32'h0,         1, 32'h8C22_0004, 0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0043, 0, 1, 32'h0,         1, 32'h8C22_0004, 0, 32'h0));
        // address moves during fill
        tbl.push_back(mk(0, 1, 32'h0000_0100, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0200, 0, 1, 32'h0,         0, 32'h0,         1, 32'h100));
        tbl.push_back(mk(0, 1, 32'h0000_0200, 0, 0, 32'hAAAA_0100, 0, 32'h0,         1, 32'h100));
        tbl.push_back(mk(0, 1, 32'h0000_0200, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0200, 0, 0, 32'hBBBB_0200, 0, 32'h0,         1, 32'h200));
        tbl.push_back(mk(0, 1, 32'h0000_0200, 0, 1, 32'h0,         1, 32'hBBBB_0200, 0, 32'h0));
        // flush in IDLE
        tbl.push_back(mk(0, 1, 32'h0000_0000, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0000, 0, 0, 32'h0000_0A00, 0, 32'h0,         1, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0004, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0004, 0, 0, 32'h0000_0A04, 0, 32'h0,         1, 32'h4));
        tbl.push_back(mk(0, 1, 32'h0000_0000, 0, 1, 32'h0,         1, 32'h0000_0A00, 0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0004, 0, 1, 32'h0,         1, 32'h0000_0A04, 0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0004, 1, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0004, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 1, 32'h0,         0, 32'h0,         1, 32'h4));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 0, 32'h0000_0A04, 0, 32'h0,         1, 32'h4));
        tbl.push_back(mk(0, 1, 32'h0000_0000, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0000, 0, 0, 32'h0000_0A00, 0, 32'h0,         1, 32'h0));
        // flush coincident with fill completion of 0x8
        tbl.push_back(mk(0, 1, 32'h0000_0008, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0008, 1, 0, 32'h0000_0A08, 0, 32'h0,         1, 32'h8));
        tbl.push_back(mk(0, 1, 32'h0000_0008, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0008, 0, 1, 32'h0,         0, 32'h0,         1, 32'h8));
        // reset while in FILL
        tbl.push_back(mk(1, 1, 32'h0000_0008, 0, 1, 32'h0,         0, 32'h0,         1, 32'h8));
        tbl.push_back(mk(0, 0, 32'h0000_0008, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0008, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        // flush while waiting in FILL
        tbl.push_back(mk(0, 1, 32'h0000_0008, 1, 1, 32'h0,         0, 32'h0,         1, 32'h8));
        tbl.push_back(mk(0, 1, 32'h0000_0008, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0008, 0, 0, 32'h0000_0A08, 0, 32'h0,         1, 32'h8));
        tbl.push_back(mk(0, 1, 32'h0000_0008, 0, 1, 32'h0,         1, 32'h0000_0A08, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));

        run_list("row", tbl);

        // counter sequence: 2 misses, 3 hits, then reset
        hand.push_back(mk(1, 0, 32'h0, 0, 1, 32'h0, 0, 32'h0, 0, 32'h0));
        hand.push_back(with_stats(mk(0, 0, 32'h0, 0, 1, 32'h0, 0, 32'h0, 0, 32'h0), 32'd0, 32'd0));
        hand.push_back(mk(0, 1, 32'h40, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        hand.push_back(mk(0, 1, 32'h40, 0, 0, 32'h1234_5678, 0, 32'h0,         1, 32'h40));
        hand.push_back(mk(0, 1, 32'h40, 0, 1, 32'h0,         1, 32'h1234_5678, 0, 32'h0));
        hand.push_back(mk(0, 1, 32'h44, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0));
        hand.push_back(mk(0, 1, 32'h44, 0, 0, 32'h9ABC_DEF0, 0, 32'h0,         1, 32'h44));
        hand.push_back(mk(0, 1, 32'h44, 0, 1, 32'h0,         1, 32'h9ABC_DEF0, 0, 32'h0));
        hand.push_back(mk(0, 1, 32'h40, 0, 1, 32'h0,         1, 32'h1234_5678, 0, 32'h0));
        hand.push_back(with_stats(mk(0, 0, 32'h0, 0, 1, 32'h0, 0, 32'h0, 0, 32'h0), 32'd3, 32'd2));
        hand.push_back(mk(0, 0, 32'h0, 1, 1, 32'h0, 0, 32'h0, 0, 32'h0));
        hand.push_back(with_stats(mk(0, 1, 32'h44, 0, 1, 32'h0, 0, 32'h0, 0, 32'h0), 32'd3, 32'd2));
        hand.push_back(mk(1, 0, 32'h0, 0, 1, 32'h0, 0, 32'h0, 1, 32'h44));
        hand.push_back(with_stats(mk(0, 0, 32'h0, 0, 1, 32'h0, 0, 32'h0, 0, 32'h0), 32'd0, 32'd0));
        hand.push_back(mk(0, 1, 32'h40, 0, 1, 32'h0, 0, 32'h0, 0, 32'h0));

        run_list("seq", hand);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
